axi4_ar_outstanding_limiter: RTL and testbench

- AR-channel credit stage placed directly downstream of the AR buffer in the RAB read path.
- Forwards read-address requests to the slave only while fewer than C_MAX_OUTSTANDING read bursts are in flight.
- Counts completions on the R channel, which passes through combinationally.
- Provides a drain handshake so the RAB can quiesce reads before a TLB reconfiguration.

---
 rtl/axi_rab_pkg.sv | 25 ++
 rtl/axi4_ar_outstanding_limiter_if.sv | 44 ++++
 rtl/axi4_ar_outstanding_limiter.sv | 136 +++++++++++++
 tb/tb_axi4_ar_outstanding_limiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rab_pkg.sv
// Shared RAB read-path definitions.
//   drain_state_e     : drain handshake states used by the AR outstanding limiter
//   RESP_*            : AXI RRESP/BRESP encodings
//   ar_payload_width  : packed AR payload width (id + addr + len + size + burst +
//                       lock + prot + cache + user), shared with the AR buffer
package axi_rab_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } drain_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // 32 addr + 8 len + 3 size + 2 burst + 1 lock + 3 prot + 4 cache = 53
    function automatic int unsigned ar_payload_width(input int unsigned id_w,
                                                     input int unsigned user_w);
        return id_w + user_w + 53;
    endfunction

endpackage

// File: rtl/axi4_ar_outstanding_limiter_if.sv
// AXI4 read bus (AR + R channels) bundle.
//   master modport : drives AR payload/arvalid and rready, receives arready and R
//   slave  modport : the mirror image
interface axi4_ar_outstanding_limiter_if #(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int C_AXI_DATA_WIDTH = 64
);
    logic [C_AXI_ID_WIDTH-1:0]   arid;
    logic [31:0]                 araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [2:0]                  arprot;
    logic [3:0]                  arcache;
    logic [C_AXI_USER_WIDTH-1:0] aruser;
    logic                        arvalid;
    logic                        arready;

    logic [C_AXI_ID_WIDTH-1:0]   rid;
    logic [C_AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arprot, arcache, aruser,
        output arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arprot, arcache, aruser,
        input  arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_ar_outstanding_limiter.sv
// AR-channel credit stage for the RAB read path.
// Forwards ARs to the slave only while fewer than C_MAX_OUTSTANDING bursts are in
// flight, counts completions (rlast beats) on the pass-through R channel, and offers
// a drain handshake to quiesce reads.
//   axi4_aclk, axi4_arst : clock, asynchronous active-high reset
//   s_axi4               : upstream side (from AR buffer / to master)
//   m_axi4               : downstream side (to slave)
//   drain_req_i          : level request to block new ARs and wait for zero in flight
//   drain_ack_o          : high while drained (IDLE)
//   outstanding_o        : registered in-flight burst count
//   err_underflow_o      : sticky, rlast completion seen with nothing outstanding
module axi4_ar_outstanding_limiter
    import axi_rab_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH    = 4,
    parameter int C_AXI_USER_WIDTH  = 4,
    parameter int C_AXI_DATA_WIDTH  = 64,
    parameter int C_MAX_OUTSTANDING = 8,
    parameter int C_CNT_WIDTH       = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                   axi4_aclk,
    input  logic                   axi4_arst,
    axi4_ar_outstanding_limiter_if.slave  s_axi4,
    axi4_ar_outstanding_limiter_if.master m_axi4,
    input  logic                   drain_req_i,
    output logic                   drain_ack_o,
    output logic [C_CNT_WIDTH-1:0] outstanding_o,
    output logic                   err_underflow_o
);

    localparam int unsigned AR_W = ar_payload_width(C_AXI_ID_WIDTH, C_AXI_USER_WIDTH);
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = C_CNT_WIDTH'(C_MAX_OUTSTANDING);

    drain_state_e           state;
    logic [C_CNT_WIDTH-1:0] cnt;
    logic [C_CNT_WIDTH-1:0] cnt_next;
    logic                   ar_pend;
    logic                   ar_pend_next;
    logic                   err;
    logic                   drain_ack;
    logic                   allow;
    logic                   ar_hs;
    logic                   r_done;
    logic                   underflow;
    logic [AR_W-1:0]        ar_payload;

    // AR payload is a straight copy; no storage.
    assign ar_payload = {s_axi4.arid, s_axi4.araddr, s_axi4.arlen, s_axi4.arsize,
                         s_axi4.arburst, s_axi4.arlock, s_axi4.arprot,
                         s_axi4.arcache, s_axi4.aruser};
    assign {m_axi4.arid, m_axi4.araddr, m_axi4.arlen, m_axi4.arsize,
            m_axi4.arburst, m_axi4.arlock, m_axi4.arprot,
            m_axi4.arcache, m_axi4.aruser} = ar_payload;

    // R channel passes straight through, independent of reset.
    assign s_axi4.rid    = m_axi4.rid;
    assign s_axi4.rdata  = m_axi4.rdata;
    assign s_axi4.rresp  = m_axi4.rresp;
    assign s_axi4.rlast  = m_axi4.rlast;
    assign s_axi4.rvalid = m_axi4.rvalid;
    assign m_axi4.rready = s_axi4.rready;

    // A pending AR keeps the gate open regardless of drain or credit, so it is never
    // withdrawn. Credit uses the registered count only, keeping R->AR non-combinational.
    // Reset closes the gate immediately.
    assign allow = ~axi4_arst & (ar_pend | ((state == ST_RUN) && (cnt < CNT_MAX)));

    assign m_axi4.arvalid = s_axi4.arvalid & allow;
    assign s_axi4.arready = m_axi4.arready & allow;

    assign ar_hs        = m_axi4.arvalid & m_axi4.arready;
    assign r_done       = m_axi4.rvalid & m_axi4.rready & m_axi4.rlast;
    assign ar_pend_next = m_axi4.arvalid & ~m_axi4.arready;

    always_comb begin
        cnt_next  = cnt;
        underflow = 1'b0;
        if (ar_hs && !r_done) begin
            cnt_next = cnt + 1'b1;
        end else if (r_done && !ar_hs) begin
            if (cnt == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            ar_pend   <= 1'b0;
            err       <= 1'b0;
            drain_ack <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            ar_pend <= ar_pend_next;
            if (underflow) begin
                err <= 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (drain_req_i && (!ar_pend || ar_hs)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // An AR that stalls on the very cycle drain is entered is still
                    // pending here; it must complete before the block reports drained.
                    if (!drain_req_i) begin
                        state <= ST_RUN;
                    end else if ((cnt_next == '0) && !ar_pend_next) begin
                        state     <= ST_IDLE;
                        drain_ack <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!drain_req_i) begin
                        state     <= ST_RUN;
                        drain_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    drain_ack <= 1'b0;
                end
            endcase
        end
    end

    assign drain_ack_o     = drain_ack;
    assign outstanding_o   = cnt;
    assign err_underflow_o = err;

endmodule

// File: tb/tb_axi4_ar_outstanding_limiter.sv
// Randomized scoreboard bench for axi4_ar_outstanding_limiter (C_MAX_OUTSTANDING=2).
// The driver picks random bus/drain activity each cycle, predicts the outputs from a
// behavioural model (in-flight count as an integer, a held-AR flag, drain mode) and
// queues them; a monitor on the falling edge pops and compares, and checks the AR
// payload seen downstream against the queue of ARs offered upstream.
module tb_axi4_ar_outstanding_limiter;
    import axi_rab_pkg::*;

    localparam int ID_W     = 4;
    localparam int USER_W   = 4;
    localparam int DATA_W   = 64;
    localparam int MAX_OUT  = 2;
    localparam int CNT_W    = $clog2(MAX_OUT + 1);
    localparam int AR_W     = ar_payload_width(ID_W, USER_W);
    localparam int RF_W     = ID_W + DATA_W + 5;
    localparam int N_CYCLES = 3000;
    localparam int RST_AT   = 1500;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             drain_req = 1'b0;
    logic             drain_ack;
    logic             err_uf;
    logic [CNT_W-1:0] outstanding;

    always #5 clk = ~clk;

    axi4_ar_outstanding_limiter_if #(
        .C_AXI_ID_WIDTH(ID_W), .C_AXI_USER_WIDTH(USER_W), .C_AXI_DATA_WIDTH(DATA_W)
    ) s_bus ();
    axi4_ar_outstanding_limiter_if #(
        .C_AXI_ID_WIDTH(ID_W), .C_AXI_USER_WIDTH(USER_W), .C_AXI_DATA_WIDTH(DATA_W)
    ) m_bus ();

    axi4_ar_outstanding_limiter #(
        .C_AXI_ID_WIDTH(ID_W),
        .C_AXI_USER_WIDTH(USER_W),
        .C_AXI_DATA_WIDTH(DATA_W),
        .C_MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .axi4_aclk(clk),
        .axi4_arst(rst),
        .s_axi4(s_bus),
        .m_axi4(m_bus),
        .drain_req_i(drain_req),
        .drain_ack_o(drain_ack),
        .outstanding_o(outstanding),
        .err_underflow_o(err_uf)
    );

    typedef struct {
        logic             m_arvalid;
        logic             s_arready;
        logic             drain_ack;
        logic             err;
        logic [CNT_W-1:0] outstanding;
        logic [RF_W-1:0]  r_fwd;
    } exp_t;

    exp_t            exp_q[$];
    logic [AR_W-1:0] ar_q[$];
    int              n_checks = 0;
    int              n_fail = 0;

    // Model state: bursts in flight, an AR offered downstream but not yet taken,
    // sticky underflow, and drain mode (0 run, 1 draining, 2 drained).
    int m_inflight, m_mode;
    bit m_hold, m_err;
    int n_inflight, n_mode;
    bit n_hold, n_err, accept;
    bit up_valid;
    logic [AR_W-1:0] up_payload;

    int cov_accept = 0, cov_blocked = 0, cov_idle = 0, cov_underflow = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_hold     = 1'b0;
        m_err      = 1'b0;
        m_mode     = 0;
    endtask

    // Monitor: compare whatever the DUT presents on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_bus.arvalid === 1'b1) begin
                if (ar_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ar_payload: downstream arvalid with no AR offered at t=%0t", $time);
                end else begin
                    check("ar_payload",
                          128'({m_bus.arid, m_bus.araddr, m_bus.arlen, m_bus.arsize,
                                m_bus.arburst, m_bus.arlock, m_bus.arprot,
                                m_bus.arcache, m_bus.aruser}),
                          128'(ar_q[0]));
                    if (m_bus.arready === 1'b1) void'(ar_q.pop_front());
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m_arvalid",   128'(m_bus.arvalid), 128'(e.m_arvalid));
                check("s_arready",   128'(s_bus.arready), 128'(e.s_arready));
                check("outstanding", 128'(outstanding),   128'(e.outstanding));
                check("drain_ack",   128'(drain_ack),     128'(e.drain_ack));
                check("err_underflow", 128'(err_uf),      128'(e.err));
                check("r_passthrough",
                      128'({s_bus.rid, s_bus.rdata, s_bus.rresp, s_bus.rlast,
                            s_bus.rvalid, m_bus.rready}),
                      128'(e.r_fwd));
            end
        end
    end

    // Driver + reference model.
    initial begin
        exp_t e;
        bit   gate, done;
        model_reset();
        up_valid      = 1'b0;
        up_payload    = '0;
        s_bus.arvalid = 1'b0;
        {s_bus.arid, s_bus.araddr, s_bus.arlen, s_bus.arsize, s_bus.arburst,
         s_bus.arlock, s_bus.arprot, s_bus.arcache, s_bus.aruser} = up_payload;
        s_bus.rready  = 1'b0;
        m_bus.arready = 1'b0;
        m_bus.rvalid  = 1'b0;
        m_bus.rlast   = 1'b0;
        m_bus.rid     = '0;
        m_bus.rdata   = '0;
        m_bus.rresp   = RESP_OKAY;
        accept        = 1'b0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            // State reached at this edge.
            if (rst) begin
                model_reset();
            end else begin
                m_inflight = n_inflight;
                m_hold     = n_hold;
                m_err      = n_err;
                m_mode     = n_mode;
                if (accept) up_valid = 1'b0;
            end

            if (cyc == 3)          rst = 1'b0;
            if (cyc == RST_AT)     rst = 1'b1;
            if (cyc == RST_AT + 2) rst = 1'b0;
            if (rst) begin
                // Asynchronous: everything clears now; upstream resets too.
                model_reset();
                up_valid = 1'b0;
                ar_q.delete();
            end

            // Random stimulus.
            if (!up_valid && !rst && ($urandom_range(99) < 60)) begin
                up_valid   = 1'b1;
                up_payload = AR_W'({$urandom(), $urandom()});
                ar_q.push_back(up_payload);
            end
            if ($urandom_range(19) == 0) drain_req = ~drain_req;
            s_bus.arvalid = up_valid;
            {s_bus.arid, s_bus.araddr, s_bus.arlen, s_bus.arsize, s_bus.arburst,
             s_bus.arlock, s_bus.arprot, s_bus.arcache, s_bus.aruser} = up_payload;
            m_bus.arready = ($urandom_range(99) < 50);
            m_bus.rvalid  = ($urandom_range(99) < 40);
            m_bus.rlast   = ($urandom_range(99) < 50);
            m_bus.rid     = ID_W'($urandom());
            m_bus.rdata   = {$urandom(), $urandom()};
            m_bus.rresp   = 2'($urandom());
            s_bus.rready  = ($urandom_range(99) < 70);

            // Predicted behaviour for this cycle.
            gate   = !rst && (m_hold || (m_mode == 0 && m_inflight < MAX_OUT));
            accept = up_valid && gate && m_bus.arready;
            done   = m_bus.rvalid && s_bus.rready && m_bus.rlast;

            e.m_arvalid   = up_valid && gate;
            e.s_arready   = m_bus.arready && gate;
            e.outstanding = CNT_W'(m_inflight);
            e.drain_ack   = (m_mode == 2);
            e.err         = m_err;
            e.r_fwd       = {m_bus.rid, m_bus.rdata, m_bus.rresp, m_bus.rlast,
                             m_bus.rvalid, s_bus.rready};
            exp_q.push_back(e);

            if (accept) cov_accept++;
            if (up_valid && !gate && !rst) cov_blocked++;
            if (m_mode == 2) cov_idle++;

            // Next state: count moves by accepted ARs minus completed bursts,
            // never below zero (that is the underflow error).
            n_inflight = m_inflight + int'(accept) - int'(done);
            n_err      = m_err;
            if (n_inflight < 0) begin
                n_inflight = 0;
                n_err      = 1'b1;
                cov_underflow++;
            end
            n_hold = up_valid && gate && !m_bus.arready;
            n_mode = m_mode;
            case (m_mode)
                0: if (drain_req && (!m_hold || accept)) n_mode = 1;
                1: if (!drain_req) n_mode = 0;
                   else if (n_inflight == 0 && !n_hold) n_mode = 2;
                default: if (!drain_req) n_mode = 0;
            endcase
        end

        @(negedge clk);
        #1;
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        check("cov_ar_accepted",  128'(cov_accept > 0),    128'(1));
        check("cov_credit_block", 128'(cov_blocked > 0),   128'(1));
        check("cov_drained_idle", 128'(cov_idle > 0),      128'(1));
        check("cov_underflow",    128'(cov_underflow > 0), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
